// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler
// Shares one AXI-Stream FIR between up to four sample streams. Each channel
// has a one-deep hold register. A round-robin arbiter moves held samples into
// a registered issue slot tagged with the channel index on f_tuser. Returning
// FIR samples are steered back to their channel by r_tuser. An in-flight
// counter caps how many samples can be inside the FIR at once.
//
// Handshake rule on every stream (s_*, f_*, r_*, m_*): a transfer happens on
// a rising clk edge where tvalid && tready are both high. A producer holding
// tvalid high without a transfer keeps tdata/tuser stable.
module fir_channel_scheduler #(
  parameter int N_CH         = 4,
  parameter int DW           = 32,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_CH-1:0]      ch_en,
  input  logic [N_CH*DW-1:0]   s_tdata,
  input  logic [N_CH-1:0]      s_tvalid,
  output logic [N_CH-1:0]      s_tready,
  output logic [DW-1:0]        f_tdata,
  output logic                 f_tvalid,
  input  logic                 f_tready,
  output logic [1:0]           f_tuser,
  input  logic [DW-1:0]        r_tdata,
  input  logic                 r_tvalid,
  output logic                 r_tready,
  input  logic [1:0]           r_tuser,
  output logic [DW-1:0]        m_tdata,
  output logic [N_CH-1:0]      m_tvalid,
  input  logic [N_CH-1:0]      m_tready,
  output logic [7:0]           inflight,
  output logic                 busy
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] hold_vld;
  logic [DW-1:0]   hold_data [N_CH];
  logic [PW-1:0]   rr_ptr;
  logic [7:0]      inflight_q;

  logic            issue_hs;
  logic            ret_hs;
  logic            slot_free;
  logic [8:0]      committed;
  logic            issue_ok;
  logic            grant_vld;
  logic [PW-1:0]   grant_idx;

  assign issue_hs  = f_tvalid && f_tready;
  assign ret_hs    = r_tvalid && r_tready;
  assign slot_free = !f_tvalid || f_tready;

  // A word leaving the slot at this edge becomes in-flight at the same edge,
  // so it is counted before a new word is allowed into the slot. This keeps
  // the count of accepted-but-unreturned samples at or below MAX_INFLIGHT.
  assign committed = {1'b0, inflight_q} + {8'd0, issue_hs};
  assign issue_ok  = slot_free && (committed < 9'(MAX_INFLIGHT));

  // Ready depends only on registered hold state and the enable.
  assign s_tready = ~hold_vld | ~ch_en;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    int c;
    grant_vld = 1'b0;
    grant_idx = '0;
    c         = 0;
    for (int k = 1; k <= N_CH; k++) begin
      c = (int'(rr_ptr) + k) % N_CH;
      if (!grant_vld && hold_vld[PW'(c)] && ch_en[PW'(c)]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(c);
      end
    end
  end

  // Hold valid flags: capture, drain on grant, flush on disable.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hold_vld <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!ch_en[i]) begin
          hold_vld[i] <= 1'b0;
        end else if (s_tvalid[i] && s_tready[i]) begin
          hold_vld[i] <= 1'b1;
        end else if (issue_ok && grant_vld && (grant_idx == PW'(i))) begin
          hold_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Hold data: loaded whenever an enabled channel transfers a sample.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (ch_en[i] && s_tvalid[i] && s_tready[i]) begin
        hold_data[i] <= s_tdata[i*DW +: DW];
      end
    end
  end

  // Issue slot toward the FIR plus the round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      f_tvalid <= 1'b0;
      f_tdata  <= '0;
      f_tuser  <= '0;
      rr_ptr   <= PW'(N_CH - 1);
    end else if (issue_ok && grant_vld) begin
      f_tvalid <= 1'b1;
      f_tdata  <= hold_data[grant_idx];
      f_tuser  <= 2'(grant_idx);
      rr_ptr   <= grant_idx;
    end else if (slot_free) begin
      f_tvalid <= 1'b0;
    end
  end

  // In-flight counter: up on issue, down on return, saturating at zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      inflight_q <= '0;
    end else if (issue_hs && !ret_hs) begin
      inflight_q <= inflight_q + 8'd1;
    end else if (!issue_hs && ret_hs && (inflight_q != 8'd0)) begin
      inflight_q <= inflight_q - 8'd1;
    end
  end

  // A return with nothing outstanding means the FIR produced an extra sample.
  assert property (@(posedge clk) disable iff (!rstn)
    !(ret_hs && !issue_hs && (inflight_q == 8'd0)));

  // Return demux: unknown channel tags are accepted and dropped.
  always_comb begin
    m_tvalid = '0;
    r_tready = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(r_tuser) == i) begin
        m_tvalid[i] = r_tvalid;
        r_tready    = m_tready[i];
      end
    end
  end

  assign m_tdata  = r_tdata;
  assign inflight = inflight_q;
  assign busy     = (|hold_vld) || f_tvalid || (inflight_q != 8'd0);

endmodule
